// File: rtl/fp_result_fifo.sv
// rtl/fp_result_fifo.sv - first-word fall-through FIFO for FP ALU results with IEEE class tagging
module fp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_class,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [2:0]       class_mem [DEPTH];
  logic [2:0]       in_class;
  logic             full, push, pop;

  // Class is derived from the double-precision exponent/mantissa; sign is ignored.
  always_comb begin
    in_class = 3'b000;
    if (in_data[62:52] == 11'h000) begin
      in_class = (in_data[51:0] == '0) ? 3'b001 : 3'b010;
    end else if (in_data[62:52] == 11'h7FF) begin
      in_class = (in_data[51:0] == '0) ? 3'b011 : 3'b100;
    end
  end

  assign full      = (count_q == FULL_COUNT);
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (in_valid && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally left uninitialised; out_data is meaningless while empty.
  always_ff @(posedge Clock) begin
    if (push && !flush) begin
      data_mem[wr_ptr_q]  <= in_data;
      class_mem[wr_ptr_q] <= in_class;
    end
  end

  assign out_data  = data_mem[rd_ptr_q];
  assign out_class = class_mem[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
